// File: rtl/board_line_clear_sequencer_if.sv
// Control and RAM-bus signal bundle between the game controller and the
// line-clear sequencer. The slave side is the sequencer itself.
interface board_line_clear_sequencer_if #(
  parameter int COLS = 10,
  parameter int CW   = 24
);
  logic                 start;
  logic                 clear_all;
  logic                 bus_grant;
  logic                 busy;
  logic                 done;
  logic [4:0]           lines_cleared;
  logic [4:0]           ram_row;
  logic [COLS-1:0]      ram_we;
  logic [COLS*CW-1:0]   ram_d;
  logic [COLS*CW-1:0]   ram_q;

  modport master (
    output start, clear_all, bus_grant, ram_q,
    input  busy, done, lines_cleared, ram_row, ram_we, ram_d
  );

  modport slave (
    input  start, clear_all, bus_grant, ram_q,
    output busy, done, lines_cleared, ram_row, ram_we, ram_d
  );
endinterface

// File: rtl/board_line_clear_sequencer.sv
// Line-clear / board-wipe sequencer for the column board RAMs.
// Reads the board bottom-up one row at a time, drops full rows, copies the
// remaining rows down to the write pointer, then zero-fills what is left on
// top. A wipe pass skips straight to the zero-fill from the bottom row.
module board_line_clear_sequencer #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  board_line_clear_sequencer_if.slave       bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR, FILL, DONE} state_t;

  // Pointers are 6 bits wide so that decrementing past row 0 sets bit 5.
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  state_t               state_reg, state_next;
  logic [5:0]           rd_reg, rd_next;
  logic [5:0]           wr_reg, wr_next;
  logic [4:0]           cnt_reg, cnt_next;
  logic [4:0]           lines_reg;
  logic [COLS*CW-1:0]   row_buf_reg;
  logic                 full_reg;

  logic [COLS-1:0]      cell_occupied;
  logic                 row_full;

  logic                 busy_c;
  logic                 done_c;
  logic [4:0]           ram_row_c;
  logic [COLS-1:0]      ram_we_c;
  logic [COLS*CW-1:0]   ram_d_c;

  // A row is full when every column holds a non-zero colour.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign cell_occupied[gi] = |bus.ram_q[gi*CW +: CW];
  end
  assign row_full = &cell_occupied;

  // State, pointers, row buffer and the held line count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_reg      <= '0;
      wr_reg      <= '0;
      cnt_reg     <= '0;
      lines_reg   <= '0;
      row_buf_reg <= '0;
      full_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      wr_reg    <= wr_next;
      cnt_reg   <= cnt_next;
      if (state_reg == RD_WAIT) begin
        row_buf_reg <= bus.ram_q;
        full_reg    <= row_full;
      end
      if (state_reg == DONE) begin
        lines_reg <= cnt_reg;
      end
    end
  end

  // Next-state, pointer updates and RAM bus drive.
  always_comb begin
    state_next = state_reg;
    rd_next    = rd_reg;
    wr_next    = wr_reg;
    cnt_next   = cnt_reg;
    busy_c     = (state_reg != IDLE);
    done_c     = 1'b0;
    ram_row_c  = '0;
    ram_we_c   = '0;
    ram_d_c    = '0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          cnt_next   = '0;
          rd_next    = ROW_LAST;
          wr_next    = ROW_LAST;
          state_next = bus.clear_all ? FILL : RD_ADDR;
        end
      end

      RD_ADDR: begin
        ram_row_c = rd_reg[4:0];
        if (bus.bus_grant) state_next = RD_WAIT;
      end

      RD_WAIT: begin
        // The read was launched on the grant edge, so no grant is needed here.
        ram_row_c  = rd_reg[4:0];
        state_next = WR;
      end

      WR: begin
        ram_row_c = wr_reg[4:0];
        if (bus.bus_grant) begin
          if (full_reg) begin
            cnt_next = cnt_reg + 5'd1;
          end else begin
            // A row that is already in place needs no rewrite.
            if (wr_reg != rd_reg) begin
              ram_we_c = '1;
              ram_d_c  = row_buf_reg;
            end
            wr_next = wr_reg - 6'd1;
          end
          rd_next = rd_reg - 6'd1;
          if (rd_next[5]) begin
            // No rows cleared means nothing left to fill: go straight to DONE.
            state_next = wr_next[5] ? DONE : FILL;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end

      FILL: begin
        ram_row_c = wr_reg[4:0];
        if (wr_reg[5]) begin
          state_next = DONE;
        end else if (bus.bus_grant) begin
          ram_we_c = '1;
          wr_next  = wr_reg - 6'd1;
          if (wr_reg == 6'd0) state_next = DONE;
        end
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy          = busy_c;
  assign bus.done          = done_c;
  assign bus.lines_cleared = lines_reg;
  assign bus.ram_row       = ram_row_c;
  assign bus.ram_we        = ram_we_c;
  assign bus.ram_d         = ram_d_c;

endmodule

// File: tb/tb_board_line_clear_sequencer.sv
// Directed bench for the line-clear sequencer with a behavioural model of
// the ten column RAMs, muxed to a scan address whenever the grant is low.
module tb_board_line_clear_sequencer;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_line_clear_sequencer_if #(.COLS(COLS), .CW(CW)) bus ();

  board_line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Board RAM model, image buffer for backdoor loading, scan address.
  logic [CW-1:0]      mem [COLS][ROWS];
  logic [CW-1:0]      img [COLS][ROWS];
  logic               load_req = 1'b0;
  logic [COLS*CW-1:0] q_reg;
  logic [4:0]         vga_row = 5'd0;

  assign bus.ram_q = q_reg;

  always @(posedge clk) begin
    vga_row <= (vga_row == 5'(ROWS - 1)) ? 5'd0 : vga_row + 5'd1;
    for (int c = 0; c < COLS; c++) begin
      if (bus.bus_grant) begin
        q_reg[c*CW +: CW] <= mem[c][bus.ram_row];
        if (bus.ram_we[c]) mem[c][bus.ram_row] <= bus.ram_d[c*CW +: CW];
      end else begin
        q_reg[c*CW +: CW] <= mem[c][vga_row];
      end
    end
    if (load_req) begin
      for (int c = 0; c < COLS; c++)
        for (int r = 0; r < ROWS; r++)
          mem[c][r] <= img[c][r];
    end
  end

  // Write-enable activity monitor.
  int we_cnt = 0;
  int we_nogrant = 0;
  int we_mixed = 0;
  always @(negedge clk) begin
    if (bus.ram_we != '0) begin
      we_cnt <= we_cnt + 1;
      if (!bus.bus_grant) we_nogrant <= we_nogrant + 1;
      if (bus.ram_we != '1) we_mixed <= we_mixed + 1;
    end
  end

  task automatic clear_img();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        img[c][r] = '0;
  endtask

  task automatic load_board();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Pulse start and count edges until done is seen (bounded).
  task automatic run_pass(input bit ca, input bit toggle, output int cycles);
    bus.clear_all = ca;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.clear_all = 1'b0;
    cycles = 1;
    while (cycles < 400 && !bus.done) begin
      if (toggle) bus.bus_grant = ~bus.bus_grant;
      @(posedge clk); #1;
      cycles++;
    end
    bus.bus_grant = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.clear_all = 1'b0; bus.bus_grant = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lines_cleared !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_status busy=%b done=%b lines=%0d want 0 0 0", bus.busy, bus.done, bus.lines_cleared);
    end
    vectors++;
    if (bus.ram_we !== '0 || bus.ram_row !== 5'd0 || bus.ram_d !== '0) begin
      miscompares++;
      $display("FAIL reset_bus we=%h row=%0d d=%h want all 0", bus.ram_we, bus.ram_row, bus.ram_d);
    end
    bus.clear_all = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.clear_all = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_all_alone busy=%b want 0", bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_empty();
    int cycles, base;
    clear_img(); load_board();
    base = we_cnt;
    run_pass(1'b0, 1'b0, cycles);
    vectors++;
    if (cycles !== 61) begin
      miscompares++;
      $display("FAIL empty_latency got %0d want 61", cycles);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.lines_cleared !== 5'd0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_lines got %0d busy=%b want 0 0", bus.lines_cleared, bus.busy);
    end
    vectors++;
    if (we_cnt - base !== 0) begin
      miscompares++;
      $display("FAIL empty_no_write got %0d writes want 0", we_cnt - base);
    end
    $display("test_empty cycles=%0d lines=%0d", cycles, bus.lines_cleared);
  endtask

  task automatic test_one_line(input bit toggle);
    int cycles, base_ng, base_mx;
    logic [CW-1:0] exp;
    clear_img();
    for (int c = 0; c < COLS; c++) img[c][19] = 24'hFF3399;
    img[0][18] = 24'h66B2FF;
    load_board();
    base_ng = we_nogrant; base_mx = we_mixed;
    run_pass(1'b0, toggle, cycles);
    vectors++;
    if (toggle ? (cycles >= 400) : (cycles !== 62)) begin
      miscompares++;
      $display("FAIL one_line_latency toggle=%0d got %0d want %s", toggle, cycles, toggle ? "<400" : "62");
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.lines_cleared !== 5'd1) begin
      miscompares++;
      $display("FAIL one_line_count got %0d want 1", bus.lines_cleared);
    end
    vectors++;
    if (we_nogrant - base_ng !== 0 || we_mixed - base_mx !== 0) begin
      miscompares++;
      $display("FAIL one_line_we nogrant=%0d mixed=%0d want 0 0", we_nogrant - base_ng, we_mixed - base_mx);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp = (r == 19 && c == 0) ? 24'h66B2FF : 24'h0;
        vectors++;
        if (mem[c][r] !== exp) begin
          miscompares++;
          $display("FAIL one_line_cell r%0d c%0d got %h want %h", r, c, mem[c][r], exp);
        end
      end
    $display("test_one_line toggle=%0d cycles=%0d lines=%0d", toggle, cycles, bus.lines_cleared);
  endtask

  task automatic test_four_lines();
    int cycles;
    logic [CW-1:0] exp;
    clear_img();
    for (int r = 16; r < 20; r++)
      for (int c = 0; c < COLS; c++) img[c][r] = {8'(r), 8'(c), 8'h01};
    img[3][15] = 24'h99FFCC;
    load_board();
    run_pass(1'b0, 1'b0, cycles);
    vectors++;
    if (cycles !== 65) begin
      miscompares++;
      $display("FAIL four_lines_latency got %0d want 65", cycles);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.lines_cleared !== 5'd4) begin
      miscompares++;
      $display("FAIL four_lines_count got %0d want 4", bus.lines_cleared);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp = (r == 19 && c == 3) ? 24'h99FFCC : 24'h0;
        vectors++;
        if (mem[c][r] !== exp) begin
          miscompares++;
          $display("FAIL four_lines_cell r%0d c%0d got %h want %h", r, c, mem[c][r], exp);
        end
      end
    $display("test_four_lines cycles=%0d lines=%0d", cycles, bus.lines_cleared);
  endtask

  task automatic test_split_lines();
    int cycles;
    logic [CW-1:0] exp;
    clear_img();
    for (int c = 0; c < COLS; c++) begin
      img[c][17] = 24'h00FF00;
      img[c][19] = 24'h000001;
    end
    img[5][18] = 24'hFFFF66;
    load_board();
    run_pass(1'b0, 1'b0, cycles);
    vectors++;
    if (cycles !== 63) begin
      miscompares++;
      $display("FAIL split_latency got %0d want 63", cycles);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.lines_cleared !== 5'd2) begin
      miscompares++;
      $display("FAIL split_count got %0d want 2", bus.lines_cleared);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp = (r == 19 && c == 5) ? 24'hFFFF66 : 24'h0;
        vectors++;
        if (mem[c][r] !== exp) begin
          miscompares++;
          $display("FAIL split_cell r%0d c%0d got %h want %h", r, c, mem[c][r], exp);
        end
      end
    $display("test_split_lines cycles=%0d lines=%0d", cycles, bus.lines_cleared);
  endtask

  task automatic test_clear_all_and_reset();
    int cycles;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) img[c][r] = 24'($urandom) | 24'h1;
    load_board();
    run_pass(1'b1, 1'b0, cycles);
    vectors++;
    if (cycles !== 21) begin
      miscompares++;
      $display("FAIL clear_all_latency got %0d want 21", cycles);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.lines_cleared !== 5'd0) begin
      miscompares++;
      $display("FAIL clear_all_count got %0d want 0", bus.lines_cleared);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        vectors++;
        if (mem[c][r] !== 24'h0) begin
          miscompares++;
          $display("FAIL clear_all_cell r%0d c%0d got %h want 0", r, c, mem[c][r]);
        end
      end
    // Reset in the middle of a wipe, while writes are under way.
    load_board();
    bus.clear_all = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.clear_all = 1'b0; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b1 || bus.ram_we !== '1) begin
      miscompares++;
      $display("FAIL midpass_active busy=%b we=%h want 1 %h", bus.busy, bus.ram_we, {COLS{1'b1}});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.ram_we !== '0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL midpass_reset busy=%b we=%h done=%b want 0 0 0", bus.busy, bus.ram_we, bus.done);
    end
    vectors++;
    if (bus.ram_row !== 5'd0 || bus.ram_d !== '0 || bus.lines_cleared !== 5'd0) begin
      miscompares++;
      $display("FAIL midpass_reset_bus row=%0d d=%h lines=%0d want 0", bus.ram_row, bus.ram_d, bus.lines_cleared);
    end
    $display("test_clear_all_and_reset cycles=%0d", cycles);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_one_line(1'b0);
    test_four_lines();
    test_split_lines();
    test_one_line(1'b1);
    test_clear_all_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
